// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_pkg
// Description : Shared types and default constants for the interrupt controller.
// Revision    : 1.0  initial release
// ============================================================================
package intr_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    localparam logic [9:0] VEC_BASE_DEF   = 10'h3C0;
    localparam int         VEC_STRIDE_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc
// Description : Lowest-set-bit index encoder with a valid flag.
// Revision    : 1.0  initial release
// ============================================================================
module prio_enc #(
    parameter int N_IRQ = 4,
    localparam int IDX_W = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scanning from the top down lets the lowest set bit overwrite the others.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl
// Description : N-channel edge-triggered interrupt controller with masking,
//               fixed priority, latched vector and preemptive nesting.
// Revision    : 1.0  initial release
// ============================================================================
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int              N_IRQ      = 4,
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(VEC_BASE_DEF),
    parameter int              VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_in,
    input  logic             ei,
    input  logic             di,
    input  logic             int_ack,
    input  logic             reti,
    output logic             int_req,
    output logic [PC_W-1:0]  vector,
    output logic [N_IRQ-1:0] in_service,
    output logic [N_IRQ-1:0] pending
);

    localparam int              IDX_W        = $clog2(N_IRQ);
    localparam logic [PC_W-1:0] c_vec_stride = PC_W'(VEC_STRIDE);

    state_e             r_state;
    logic [IDX_W-1:0]   r_sel;
    logic [PC_W-1:0]    r_vector;
    logic [N_IRQ-1:0]   r_irq_q;
    logic [N_IRQ-1:0]   r_mask;
    logic               r_gie;
    logic [N_IRQ-1:0]   r_pending;
    logic [N_IRQ-1:0]   r_in_service;

    state_e             w_state_nxt;
    logic [IDX_W-1:0]   w_sel_nxt;
    logic [PC_W-1:0]    w_vector_nxt;
    logic               w_take;
    logic               w_gie_nxt;
    logic [N_IRQ-1:0]   w_edge;
    logic [N_IRQ-1:0]   w_below;
    logic [N_IRQ-1:0]   w_eligible;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_valid;
    logic [IDX_W-1:0]   w_isr_idx;
    logic               w_isr_valid;
    logic [N_IRQ-1:0]   w_ack_clr;
    logic [N_IRQ-1:0]   w_isr_clr;
    logic [N_IRQ-1:0]   w_pending_nxt;
    logic [N_IRQ-1:0]   w_in_service_nxt;

    assign w_edge = irq & ~r_irq_q;

    prio_enc #(.N_IRQ(N_IRQ)) u_isr_enc (
        .req   (r_in_service),
        .idx   (w_isr_idx),
        .valid (w_isr_valid)
    );

    // Only channels strictly above the current service level may preempt.
    always_comb begin
        w_below = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_below[i] = !w_isr_valid || (i < int'(w_isr_idx));
        end
    end

    assign w_eligible = r_pending & r_mask & w_below & {N_IRQ{r_gie}};

    prio_enc #(.N_IRQ(N_IRQ)) u_win_enc (
        .req   (w_eligible),
        .idx   (w_win_idx),
        .valid (w_win_valid)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_vector_nxt = r_vector;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt  = REQ;
                    w_sel_nxt    = w_win_idx;
                    w_vector_nxt = VEC_BASE + PC_W'(w_win_idx) * c_vec_stride;
                end
            end
            REQ: begin
                if (int_ack) begin
                    w_take      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (di) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A fresh edge on the acknowledged channel is OR-ed in after the clear.
    always_comb begin
        w_ack_clr        = w_take ? (N_IRQ'(1) << r_sel) : '0;
        w_isr_clr        = (reti && w_isr_valid) ? (N_IRQ'(1) << w_isr_idx) : '0;
        w_pending_nxt    = (r_pending & ~w_ack_clr) | w_edge;
        w_in_service_nxt = (r_in_service & ~w_isr_clr) | w_ack_clr;
        w_gie_nxt        = r_gie;
        if (ei || reti) begin
            w_gie_nxt = 1'b1;
        end
        if (di || w_take) begin
            w_gie_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_vector     <= VEC_BASE;
            r_irq_q      <= '0;
            r_mask       <= '0;
            r_gie        <= 1'b0;
            r_pending    <= '0;
            r_in_service <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_vector     <= w_vector_nxt;
            r_irq_q      <= irq;
            r_mask       <= mask_we ? mask_in : r_mask;
            r_gie        <= w_gie_nxt;
            r_pending    <= w_pending_nxt;
            r_in_service <= w_in_service_nxt;
        end
    end

    assign int_req    = (r_state == REQ);
    assign vector     = r_vector;
    assign in_service = r_in_service;
    assign pending    = r_pending;

endmodule
`default_nettype wire
